// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the core and the data-memory responder.
// A request transfers on the rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        err;
   logic [1:0]  dbg_state;

   modport master (
      output req_valid, MemRead, MemWrite, funct3, addr, wdata,
      input  req_ready, resp_valid, rdata, err, dbg_state
   );

   modport slave (
      input  req_valid, MemRead, MemWrite, funct3, addr, wdata,
      output req_ready, resp_valid, rdata, err, dbg_state
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane stores, extended loads,
// programmable read latency and an error response for misaligned/illegal accesses.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int RD_LATENCY  = 1
) (
   input  logic                clk,
   input  logic                reset,
   data_mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [2:0] CNT_INIT = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t        state, state_d;
   logic [2:0]    cnt, cnt_d;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          cap_rd, cap_wr;
   logic [2:0]    cap_f3;
   logic [31:0]   cap_addr;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          f_rd, f_wr;
   logic [2:0]    f_f3;
   logic [31:0]   f_addr;
   logic [AW-1:0] f_idx;
   logic [31:0]   f_word;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   f_ld;
   logic          f_err;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic          accept, store_we, resp_load;
   logic          unused_addr;

   // Decode runs on the live bus while idle and on the captured request while waiting.
   always_comb begin
      f_rd   = (state == IDLE) ? bus.MemRead  : cap_rd;
      f_wr   = (state == IDLE) ? bus.MemWrite : cap_wr;
      f_f3   = (state == IDLE) ? bus.funct3   : cap_f3;
      f_addr = (state == IDLE) ? bus.addr     : cap_addr;
   end

   assign f_idx       = f_addr[AW+1:2];
   assign f_word      = mem[f_idx];
   assign unused_addr = ^f_addr[31:AW+2];
   assign lane_h      = f_addr[1] ? f_word[31:16] : f_word[15:0];
   assign lane_b      = f_addr[1] ? (f_addr[0] ? f_word[31:24] : f_word[23:16])
                                  : (f_addr[0] ? f_word[15:8]  : f_word[7:0]);

   always_comb begin
      f_err = (f_rd == f_wr);
      case (f_f3)
         3'b000:  ;
         3'b001:  if (f_addr[0]) f_err = 1'b1;
         3'b010:  if (f_addr[1:0] != 2'b00) f_err = 1'b1;
         3'b100:  if (f_wr) f_err = 1'b1;
         3'b101:  if (f_wr || f_addr[0]) f_err = 1'b1;
         default: f_err = 1'b1;
      endcase
   end

   always_comb begin
      f_ld = f_word;
      case (f_f3)
         3'b000:  f_ld = {{24{lane_b[7]}}, lane_b};
         3'b100:  f_ld = {24'd0, lane_b};
         3'b001:  f_ld = {{16{lane_h[15]}}, lane_h};
         3'b101:  f_ld = {16'd0, lane_h};
         default: f_ld = f_word;
      endcase
   end

   always_comb begin
      be    = 4'b0000;
      wlane = bus.wdata;
      case (f_f3)
         3'b000: begin
            be[f_addr[1:0]] = 1'b1;
            wlane           = {4{bus.wdata[7:0]}};
         end
         3'b001: begin
            be    = f_addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{bus.wdata[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      accept        = 1'b0;
      resp_load     = 1'b0;
      bus.req_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = !reset;
            accept        = bus.req_valid && !reset;
            if (accept) begin
               if (f_rd && !f_wr && !f_err && (RD_LATENCY > 0)) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d   = RESP;
                  resp_load = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               state_d   = RESP;
               resp_load = 1'b1;
            end else begin
               cnt_d = cnt - 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign store_we = accept && f_wr && !f_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         cap_rd   <= 1'b0;
         cap_wr   <= 1'b0;
         cap_f3   <= 3'd0;
         cap_addr <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (accept) begin
            cap_rd   <= bus.MemRead;
            cap_wr   <= bus.MemWrite;
            cap_f3   <= bus.funct3;
            cap_addr <= bus.addr;
         end
         if (resp_load) begin
            err_q   <= f_err;
            rdata_q <= (f_err || f_wr) ? 32'd0 : f_ld;
         end
      end
   end

   // RAM is deliberately not reset; store_we is already gated by reset through accept.
   always_ff @(posedge clk) begin
      if (store_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[f_idx][8*b +: 8] <= wlane[8*b +: 8];
         end
      end
   end

   assign bus.resp_valid = (state == RESP);
   assign bus.rdata      = rdata_q;
   assign bus.err        = err_q;
   assign bus.dbg_state  = state;
endmodule
